uart_tx: RTL and testbench

- Serial UART transmitter; the transmit-side counterpart of the team's UART receiver.
- Accepts a parallel byte with a one-cycle valid strobe and shifts out one frame, LSB first: start bit (0), data bits, optional parity bit, stop bit (1).
- Bit timing is PRESCALE clocks per bit (default 8, matching the receiver's 8x oversampling at 8 MHz).
- Sits between the host data path and the serial line.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_if.sv | 24 ++
 rtl/uart_parity_calc.sv | 15 +
 rtl/uart_tx.sv | 120 ++++++++++++
 tb/tb_uart_tx.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmitter and receiver: state encoding,
// parity-type constants and default frame geometry.
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_PRESCALE   = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side bundle of the UART transmitter: byte request in, serial line and
// busy flag out.
interface uart_tx_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    input  TX_OUT, BUSY
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP,
    output TX_OUT, BUSY
  );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity bit for a data word; shared by the TX generator and
// the RX checker.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional parity, stop bit,
// each held for PRESCALE clocks. TX_OUT comes straight from a flop.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int PRESCALE   = DEF_PRESCALE
) (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave bus
);

  localparam int PW = $clog2(PRESCALE);
  localparam int BW = $clog2(DATA_WIDTH) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;
  logic                  parity;
  logic                  bit_end;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (bus.P_DATA),
    .par_typ (bus.PAR_TYP),
    .parity  (parity)
  );

  assign bit_end = (presc_q == PRESC_LAST);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    par_en_d = par_en_q;
    par_d    = par_q;
    tx_d     = 1'b1;

    if (state_q != S_IDLE) begin
      presc_d = bit_end ? '0 : presc_q + PW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (bus.DATA_VALID) begin
          state_d  = S_START;
          shift_d  = bus.P_DATA;
          par_en_d = bus.PAR_EN;
          par_d    = parity;
          presc_d  = '0;
          bit_d    = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            state_d = par_en_q ? S_PARITY : S_STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Line level is decoded from the next state so it lands in the flop
    // together with the state it belongs to.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_en_q <= par_en_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.BUSY   = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: a frame-level model queues expected frames on
// accept, and a line monitor checks every serial cycle against them.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int P  = 8;

  typedef struct {
    logic [DW-1:0] data;
    logic          par_en;
    logic          par_typ;
    int            acc;
  } frame_t;

  logic clk = 1'b0;
  logic rst;

  uart_tx_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  frame_t q[$];
  frame_t cur;
  int     cyc        = 0;
  int     rem        = 0;
  int     abort_cnt  = 0;
  int     abort_seen = 0;
  int     timeouts   = 0;
  int     checks     = 0;
  int     errors     = 0;
  int     idx        = 0;
  bit     mon_active = 1'b0;
  bit     done       = 1'b0;

  function automatic int flen(input frame_t f);
    return (DW + 2 + (f.par_en ? 1 : 0)) * P;
  endfunction

  // Expected line level for bit slot s of a frame.
  function automatic logic slot_bit(input frame_t f, input int s);
    if (s == 0) return 1'b0;
    if (s <= DW) return f.data[s-1];
    if (s == DW + 1 && f.par_en) return (^f.data) ^ f.par_typ;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic frame_step();
    check($sformatf("tx_bit slot %0d", idx / P), {31'd0, bus.TX_OUT}, {31'd0, slot_bit(cur, idx / P)});
    check("busy_in_frame", {31'd0, bus.BUSY}, 32'd1);
    idx++;
    if (idx == flen(cur)) mon_active = 1'b0;
  endtask

  // Reference model: line is free again only after a full frame has elapsed.
  always @(posedge clk) begin
    frame_t f;
    cyc++;
    if (rst) begin
      rem = 0;
      abort_cnt++;
    end else if (rem > 0) begin
      rem--;
    end else if (bus.DATA_VALID) begin
      f.data    = bus.P_DATA;
      f.par_en  = bus.PAR_EN;
      f.par_typ = bus.PAR_TYP;
      f.acc     = cyc;
      q.push_back(f);
      rem = flen(f);
    end
  end

  always @(negedge clk) begin
    if (abort_cnt != abort_seen) begin
      abort_seen = abort_cnt;
      mon_active = 1'b0;
      q.delete();
      check("reset_tx_out", {31'd0, bus.TX_OUT}, 32'd1);
      check("reset_busy", {31'd0, bus.BUSY}, 32'd0);
    end else if (mon_active) begin
      frame_step();
    end else if (bus.TX_OUT === 1'b0) begin
      if (q.size() == 0) begin
        check("unexpected_start", {31'd0, bus.TX_OUT}, 32'd1);
      end else begin
        cur = q.pop_front();
        check("start_cycle", cyc, cur.acc);
        idx        = 0;
        mon_active = 1'b1;
        frame_step();
      end
    end else begin
      check("idle_busy", {31'd0, bus.BUSY}, 32'd0);
      check("idle_tx_out", {31'd0, bus.TX_OUT}, 32'd1);
      if (q.size() > 0 && cyc > q[0].acc) begin
        check("start_cycle", cyc, q[0].acc);
        void'(q.pop_front());
      end
    end

    if (done) begin
      check("queue_drained", q.size(), 32'd0);
      check("wait_timeouts", timeouts, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.DATA_VALID = 1'b1;
    tick();
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = DW'($urandom);
    bus.PAR_EN     = 1'($urandom);
    bus.PAR_TYP    = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rem != 0 || q.size() != 0 || mon_active) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) timeouts++;
    tick();
  endtask

  initial begin
    rst            = 1'b1;
    bus.DATA_VALID = 1'b0;
    bus.P_DATA     = '0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) tick();

    send(8'h55, 1'b1, PAR_EVEN);
    wait_idle();
    send(8'hA3, 1'b1, PAR_ODD);
    wait_idle();
    send(8'hA3, 1'b0, PAR_EVEN);
    wait_idle();

    // Back-to-back with DATA_VALID held high across both frames.
    bus.P_DATA     = 8'h0F;
    bus.PAR_EN     = 1'b1;
    bus.PAR_TYP    = PAR_EVEN;
    bus.DATA_VALID = 1'b1;
    tick();
    bus.P_DATA = 8'hF0;
    repeat ((DW + 3) * P + 1) tick();
    bus.DATA_VALID = 1'b0;
    wait_idle();

    // Request while busy must be dropped.
    send(8'h55, 1'b1, PAR_EVEN);
    repeat (20) tick();
    bus.P_DATA     = 8'hFF;
    bus.DATA_VALID = 1'b1;
    tick();
    bus.DATA_VALID = 1'b0;
    wait_idle();
    repeat (40) tick();

    // Reset during data bit 3, then a clean frame.
    send(8'h55, 1'b1, PAR_EVEN);
    repeat (33) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(8'h81, 1'b1, PAR_EVEN);
    wait_idle();

    for (int i = 0; i < 3000; i++) begin
      bus.DATA_VALID = ($urandom_range(0, 5) == 0);
      bus.P_DATA     = DW'($urandom);
      bus.PAR_EN     = 1'($urandom);
      bus.PAR_TYP    = 1'($urandom);
      tick();
    end
    bus.DATA_VALID = 1'b0;
    wait_idle();

    done = 1'b1;
    repeat (5) tick();
    $display("FAIL end_of_test: monitor did not close the run");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
